// File: rtl/alu_pkg.sv
// Shared ALU op encoding and BIST constants for the ALU self-test driver.
// Imported by alu_bist_driver and alu_bist_misr.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_OP_B = 4'd10
    } alu_op_t;

    localparam int          ALU_NUM_OPS    = 11;
    localparam logic [31:0] BIST_LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] BIST_MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] BIST_MISR_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_t;

    // Right-shifting Galois LFSR: the bit falling out of position 0 folds back into the taps.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? BIST_LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] f_swap_halves(input logic [31:0] s);
        return {s[15:0], s[31:16]};
    endfunction

endpackage

// File: rtl/alu_bist_driver_if.sv
// Operand/op/result bus between the BIST driver (master) and the ALU (slave).
// Purely combinational wiring; no clock in the interface.
interface alu_bist_driver_if;

    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_data;

    modport master (
        output operand_a,
        output operand_b,
        output alu_op,
        input  alu_data
    );

    modport slave (
        input  operand_a,
        input  operand_b,
        input  alu_op,
        output alu_data
    );

endinterface

// File: rtl/alu_bist_misr.sv
// 32-bit multiple-input signature register with synchronous init and enable.
// o_sig_nxt exposes the value that would be absorbed this cycle.
module alu_bist_misr
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [31:0] i_data,
    output logic [31:0] o_sig,
    output logic [31:0] o_sig_nxt
);

    logic [31:0] r_sig;
    logic [31:0] w_sig_nxt;

    assign w_sig_nxt = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? BIST_MISR_POLY : 32'h0) ^ i_data;

    // Init wins over enable so a start edge always opens with a clean signature.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= BIST_MISR_INIT;
        end else if (i_init) begin
            r_sig <= BIST_MISR_INIT;
        end else if (i_en) begin
            r_sig <= w_sig_nxt;
        end
    end

    assign o_sig     = r_sig;
    assign o_sig_nxt = w_sig_nxt;

endmodule

// File: rtl/alu_bist_driver.sv
// ALU BIST initiator: LFSR operands, op-major sweep of all ALU ops, MISR compaction.
// Optional per-vector reference check enabled by defining ALU_REF_CHECK_EN.
module alu_bist_driver
    import alu_pkg::*;
#(
    parameter int          P_VECS_PER_OP = 16,
    parameter logic [31:0] P_SEED        = 32'hACE1_2024,
    parameter logic [31:0] P_GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    alu_bist_driver_if.master   alu_bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [31:0]         o_signature,
    output logic                o_mismatch,
    output logic [15:0]         o_fail_idx
);

    localparam logic [11:0] LP_VEC_LAST = 12'(P_VECS_PER_OP - 1);
    localparam logic [3:0]  LP_OP_LAST  = 4'(ALU_NUM_OPS - 1);

    bist_state_t r_state;
    bist_state_t w_state_nxt;
    logic        w_start_acc;
    logic        w_last;
    logic        w_run;

    logic [31:0] r_lfsr;
    logic [31:0] w_lfsr_nxt;
    logic [31:0] r_operand_a;
    logic [31:0] r_operand_b;
    logic [3:0]  r_op;
    logic [11:0] r_vec;
    logic        r_pass;
    logic [31:0] w_sig;
    logic [31:0] w_sig_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_last      = (r_op == LP_OP_LAST) && (r_vec == LP_VEC_LAST);
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_lfsr_nxt = f_lfsr_step(r_lfsr);

    // Each RUN edge absorbs the current vector and presents the next one; the last edge parks the bus at 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr      <= P_SEED;
            r_operand_a <= 32'h0;
            r_operand_b <= 32'h0;
            r_op        <= 4'h0;
            r_vec       <= 12'h0;
            r_pass      <= 1'b0;
        end else if (w_start_acc) begin
            r_lfsr      <= P_SEED;
            r_operand_a <= P_SEED;
            r_operand_b <= f_swap_halves(P_SEED);
            r_op        <= 4'h0;
            r_vec       <= 12'h0;
            r_pass      <= 1'b0;
        end else if (w_run) begin
            if (w_last) begin
                r_operand_a <= 32'h0;
                r_operand_b <= 32'h0;
                r_op        <= 4'h0;
                r_pass      <= (w_sig_nxt == P_GOLDEN_SIG);
            end else begin
                r_lfsr      <= w_lfsr_nxt;
                r_operand_a <= w_lfsr_nxt;
                r_operand_b <= f_swap_halves(w_lfsr_nxt);
                if (r_vec == LP_VEC_LAST) begin
                    r_vec <= 12'h0;
                    r_op  <= (r_op == LP_OP_LAST) ? r_op : r_op + 4'h1;
                end else begin
                    r_vec <= r_vec + 12'h1;
                end
            end
        end
    end

    alu_bist_misr u_misr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_init    (w_start_acc),
        .i_en      (w_run),
        .i_data    (alu_bus.alu_data),
        .o_sig     (w_sig),
        .o_sig_nxt (w_sig_nxt)
    );

`ifdef ALU_REF_CHECK_EN
    logic [15:0] r_k;
    logic        r_mismatch;
    logic [15:0] r_fail_idx;
    logic [31:0] w_ref;

    function automatic logic [31:0] f_alu_ref(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] res;
        res = 32'h0;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLT:  res = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU: res = {31'h0, a < b};
            ALU_XOR:  res = a ^ b;
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_SLL:  res = a << b[4:0];
            ALU_SRL:  res = a >> b[4:0];
            ALU_SRA:  res = 32'($signed(a) >>> b[4:0]);
            ALU_OP_B: res = b;
            default:  res = 32'h0;
        endcase
        return res;
    endfunction

    assign w_ref = f_alu_ref(r_op, r_operand_a, r_operand_b);

    // Only the first mismatching vector is recorded; later ones leave the index alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k        <= 16'h0;
            r_mismatch <= 1'b0;
            r_fail_idx <= 16'h0;
        end else if (w_start_acc) begin
            r_k        <= 16'h0;
            r_mismatch <= 1'b0;
            r_fail_idx <= 16'h0;
        end else if (w_run) begin
            r_k <= r_k + 16'h1;
            if ((alu_bus.alu_data != w_ref) && !r_mismatch) begin
                r_mismatch <= 1'b1;
                r_fail_idx <= r_k;
            end
        end
    end

    assign o_mismatch = r_mismatch;
    assign o_fail_idx = r_fail_idx;
`else
    assign o_mismatch = 1'b0;
    assign o_fail_idx = 16'h0;
`endif

    assign alu_bus.operand_a = r_operand_a;
    assign alu_bus.operand_b = r_operand_b;
    assign alu_bus.alu_op    = r_op;

    assign o_busy      = w_run;
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = r_pass;
    assign o_signature = w_sig;

endmodule
